// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: the manager state enum and the response codes.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESP         = 3'd5
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle; clock and reset are carried for subordinates and never driven by the manager.
interface axi4_lite #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WIDTH      = 32
) (
  input logic aclk,
  input logic areset
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [WIDTH-1:0]        wdata;
  logic [WIDTH/8-1:0]      wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [WIDTH-1:0]        rdata;
  logic [1:0]              rresp;

  modport manager (
    output awvalid, awaddr, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport subordinate (
    input aclk, areset,
    input awvalid, awaddr, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axi4_lite_manager.sv
// Single-outstanding AXI4-Lite manager bridging a local request/response port onto AW/W/B/AR/R.
module axi4_lite_manager
  import axi4_lite_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [WIDTH/8-1:0]    req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  axi4_lite.manager             axi
);

  localparam int unsigned STRB_W = WIDTH / 8;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_addr[1:0] != 2'b00) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_write) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W retire independently; B opens once both have handshaken.
      WR_ADDR_DATA: begin
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (axi.bvalid) begin
          state_d     = RESP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = resp_is_err(axi.bresp);
          rsp_rdata_d = '0;
        end
      end

      RD_ADDR: begin
        if (axi.arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      RD_DATA: begin
        if (axi.rvalid) begin
          state_d     = RESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = resp_is_err(axi.rresp);
          rsp_rdata_d = axi.rdata;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.bready  = bready_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.rready  = rready_q;

  // write_q is retained so the accepted request is fully held until IDLE.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_axi4_lite_manager.sv
// Bench: gpio-like subordinate with programmable ready delays plus a transaction-level reference model.
module tb_axi4_lite_manager;
  import axi4_lite_pkg::*;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam logic [31:0] RO_CONST   = 32'hC0FF_EE01;
  localparam int          TMO        = 200;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  axi4_lite #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)) axi (.aclk(aclk), .areset(areset));

  axi4_lite_manager #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi(axi.manager)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Subordinate: 16 words at 0x00-0x3C, word 0x4 read-only, anything above 0x3C is SLVERR.
  int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] smem [16];
  logic        aw_have_q, w_have_q, ar_have_q, bvalid_q, rvalid_q;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q, rdata_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q, rresp_q;
  int unsigned aw_cnt_q, w_cnt_q, b_cnt_q, ar_cnt_q, r_cnt_q;
  logic        aw_hs, w_hs, ar_hs, wr_both, wr_go, wr_ok, rd_pend, rd_go, rd_ok;
  logic [31:0] wa, wd, ra;
  logic [3:0]  ws;

  assign axi.awready = axi.awvalid && !aw_have_q && (aw_cnt_q >= aw_dly);
  assign axi.wready  = axi.wvalid && !w_have_q && (w_cnt_q >= w_dly);
  assign axi.arready = axi.arvalid && !ar_have_q && !rvalid_q && (ar_cnt_q >= ar_dly);
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  always_comb begin
    aw_hs   = axi.awvalid && axi.awready;
    w_hs    = axi.wvalid && axi.wready;
    ar_hs   = axi.arvalid && axi.arready;
    wa      = aw_hs ? axi.awaddr : aw_addr_q;
    wd      = w_hs ? axi.wdata : w_data_q;
    ws      = w_hs ? axi.wstrb : w_strb_q;
    ra      = ar_hs ? axi.araddr : ar_addr_q;
    wr_both = (aw_have_q || aw_hs) && (w_have_q || w_hs) && !bvalid_q;
    wr_go   = wr_both && (b_cnt_q >= b_dly);
    wr_ok   = (wa[31:6] == '0) && (wa[5:2] != 4'd1);
    rd_pend = (ar_have_q || ar_hs) && !rvalid_q;
    rd_go   = rd_pend && (r_cnt_q >= r_dly);
    rd_ok   = (ra[31:6] == '0);
  end

  always_ff @(posedge axi.aclk or posedge axi.areset) begin
    if (axi.areset) begin
      aw_have_q <= 1'b0; w_have_q <= 1'b0; ar_have_q <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; ar_addr_q <= '0; rdata_q <= '0;
      bresp_q <= OKAY; rresp_q <= OKAY;
      aw_cnt_q <= 0; w_cnt_q <= 0; b_cnt_q <= 0; ar_cnt_q <= 0; r_cnt_q <= 0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_have_q <= 1'b1; aw_addr_q <= axi.awaddr; aw_cnt_q <= 0;
      end else if (axi.awvalid && !aw_have_q) aw_cnt_q <= aw_cnt_q + 1;
      if (w_hs) begin
        w_have_q <= 1'b1; w_data_q <= axi.wdata; w_strb_q <= axi.wstrb; w_cnt_q <= 0;
      end else if (axi.wvalid && !w_have_q) w_cnt_q <= w_cnt_q + 1;
      if (wr_go) begin
        aw_have_q <= 1'b0; w_have_q <= 1'b0; b_cnt_q <= 0; bvalid_q <= 1'b1;
        bresp_q <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) smem[wa[5:2]] <= merge(smem[wa[5:2]], wd, ws);
      end else if (wr_both) b_cnt_q <= b_cnt_q + 1;
      if (bvalid_q && axi.bready) bvalid_q <= 1'b0;

      if (ar_hs) begin
        ar_have_q <= 1'b1; ar_addr_q <= axi.araddr; ar_cnt_q <= 0;
      end else if (axi.arvalid && !ar_have_q) ar_cnt_q <= ar_cnt_q + 1;
      if (rd_go) begin
        ar_have_q <= 1'b0; r_cnt_q <= 0; rvalid_q <= 1'b1;
        rresp_q <= rd_ok ? OKAY : SLVERR;
        rdata_q <= !rd_ok ? 32'h0 : (ra[5:2] == 4'd1) ? RO_CONST : smem[ra[5:2]];
      end else if (rd_pend) r_cnt_q <= r_cnt_q + 1;
      if (rvalid_q && axi.rready) rvalid_q <= 1'b0;
    end
  end

  // Reference model: expected response per accepted request, from the memory map rules.
  typedef struct packed { logic err; logic [31:0] rdata; } rsp_t;
  logic [31:0] model_mem [16];
  rsp_t        exp_q [$];

  function automatic rsp_t model_txn(input logic wr, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] s);
    rsp_t r;
    logic [3:0] idx;
    r.err = 1'b0;
    r.rdata = 32'h0;
    idx = a[5:2];
    if (a[1:0] != 2'b00 || a >= 32'h40) r.err = 1'b1;
    else if (wr) begin
      if (idx == 4'd1) r.err = 1'b1;
      else model_mem[idx] = merge(model_mem[idx], d, s);
    end else r.rdata = (idx == 4'd1) ? RO_CONST : model_mem[idx];
    return r;
  endfunction

  logic        busy, cur_mis, aw_done, w_done, saw_axi_valid;
  logic        p_aw_hold, p_w_hold, p_ar_hold, p_rsp_hold, p_err;
  logic [31:0] p_rdata, acc_addr, acc_wdata;
  logic [3:0]  acc_wstrb;
  int          lat, rsp_lat, aw_hs_lat, w_hs_lat, bready_lat;

  task automatic model_reset();
    busy = 0; cur_mis = 0; aw_done = 0; w_done = 0; saw_axi_valid = 0;
    p_aw_hold = 0; p_w_hold = 0; p_ar_hold = 0; p_rsp_hold = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
  endtask

  initial begin
    model_reset();
    lat = 0; rsp_lat = -1; aw_hs_lat = -1; w_hs_lat = -1; bready_lat = -1;
    p_err = 0; p_rdata = 0; acc_addr = 0; acc_wdata = 0; acc_wstrb = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        chk("reset_outputs", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                              rsp_valid}, 32'h0);
        model_reset();
        continue;
      end
      chk("req_ready", req_ready, !busy);
      if (p_aw_hold) chk("awvalid_held", axi.awvalid, 1);
      if (p_w_hold)  chk("wvalid_held", axi.wvalid, 1);
      if (p_ar_hold) chk("arvalid_held", axi.arvalid, 1);
      if (p_rsp_hold) begin
        chk("rsp_valid_held", rsp_valid, 1);
        chk("rsp_err_stable", rsp_err, p_err);
        chk("rsp_rdata_stable", rsp_rdata, p_rdata);
      end
      if (busy) begin
        lat++;
        if (axi.awvalid || axi.wvalid || axi.arvalid) saw_axi_valid = 1;
        if (cur_mis) chk("mis_no_axi_valid", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
        if (axi.awvalid) chk("awaddr", axi.awaddr, acc_addr);
        if (axi.arvalid) chk("araddr", axi.araddr, acc_addr);
        if (axi.wvalid) begin
          chk("wdata", axi.wdata, acc_wdata);
          chk("wstrb", axi.wstrb, acc_wstrb);
        end
        if (aw_done) chk("awvalid_cleared", axi.awvalid, 0);
        if (w_done)  chk("wvalid_cleared", axi.wvalid, 0);
        if (axi.bready) begin
          chk("bready_after_aw_w", aw_done && w_done, 1);
          if (bready_lat < 0) bready_lat = lat;
        end
        if (axi.awvalid && axi.awready) begin aw_done = 1; aw_hs_lat = lat; end
        if (axi.wvalid && axi.wready)   begin w_done = 1;  w_hs_lat = lat;  end
        if (rsp_valid) begin
          if (rsp_lat < 0) rsp_lat = lat;
          chk("rsp_expected_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            chk("rsp_err", rsp_err, exp_q[0].err);
            chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          end
          if (rsp_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            busy = 0;
          end
        end
      end else chk("rsp_valid_when_idle", rsp_valid, 0);
      p_aw_hold  = axi.awvalid && !axi.awready;
      p_w_hold   = axi.wvalid && !axi.wready;
      p_ar_hold  = axi.arvalid && !axi.arready;
      p_rsp_hold = rsp_valid && !rsp_ready;
      p_err = rsp_err;
      p_rdata = rsp_rdata;
      if (req_valid && req_ready) begin
        exp_q.push_back(model_txn(req_write, req_addr, req_wdata, req_wstrb));
        busy = 1; lat = 0; rsp_lat = -1; aw_hs_lat = -1; w_hs_lat = -1; bready_lat = -1;
        aw_done = 0; w_done = 0; saw_axi_valid = 0;
        cur_mis = (req_addr[1:0] != 2'b00);
        acc_addr = req_addr; acc_wdata = req_wdata; acc_wstrb = req_wstrb;
      end
    end
  end

  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic err, output logic [31:0] rd);
    int n;
    err = 1'bx; rd = 'x;
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    rsp_ready = (hold == 0);
    n = 0;
    do begin @(negedge aclk); n++; end while (!req_ready && n < TMO);
    if (!req_ready) begin chk("accept_timeout", req_ready, 1); req_valid = 0; return; end
    @(posedge aclk); #1;
    req_valid = 0; req_write = $urandom_range(0, 1); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    n = 0;
    do begin @(negedge aclk); n++; end while (!rsp_valid && n < TMO);
    if (!rsp_valid) begin chk("rsp_timeout", rsp_valid, 1); return; end
    err = rsp_err; rd = rsp_rdata;
    if (hold > 0) begin
      repeat (hold) @(posedge aclk);
      #1 rsp_ready = 1;
      @(negedge aclk);
    end
    @(posedge aclk); #1 rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r, a;
    int          n, pick;
    areset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(posedge aclk);
    #1 areset = 0;
    @(negedge aclk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_axi_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    @(posedge aclk); #1;

    do_txn(1, 32'h0, 32'h0000_FFFF, 4'hF, 0, e, r);
    chk("gpio_write_err", e, 0);
    chk("write_min_latency", rsp_lat, 3);
    do_txn(0, 32'h0, 32'h0, 4'h0, 0, e, r);
    chk("gpio_readback", r, 32'h0000_FFFF);
    chk("gpio_read_err", e, 0);
    chk("read_min_latency", rsp_lat, 3);

    do_txn(1, 32'h4, 32'h1234_5678, 4'hF, 0, e, r);
    chk("ro_write_err", e, 1);
    chk("ro_write_rdata", r, 0);

    do_txn(0, 32'h2, 32'h0, 4'h0, 0, e, r);
    chk("misaligned_err", e, 1);
    chk("misaligned_rdata", r, 0);
    chk("misaligned_latency", rsp_lat, 1);
    chk("misaligned_no_axi", saw_axi_valid, 0);

    aw_dly = 1; w_dly = 3;
    do_txn(1, 32'h8, 32'hA5A5_3C3C, 4'b0101, 0, e, r);
    chk("split_aw_hs_cycle", aw_hs_lat, 2);
    chk("split_w_hs_cycle", w_hs_lat, 4);
    chk("split_bready_cycle", bready_lat, 5);
    chk("split_rsp_latency", rsp_lat, 6);
    chk("split_err", e, 0);
    aw_dly = 0; w_dly = 0;

    do_txn(0, 32'h8, 32'h0, 4'h0, 5, e, r);
    chk("held_rsp_rdata", r, 32'h00A5_003C);
    chk("held_rsp_err", e, 0);

    r_dly = 6;
    req_valid = 1; req_write = 0; req_addr = 32'h0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!axi.rready && n < TMO);
    chk("reach_rd_data", axi.rready, 1);
    @(posedge aclk); #1;
    req_valid = 0;
    areset = 1;
    #1;
    chk("async_reset_drop", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                             rsp_valid}, 0);
    chk("async_reset_req_ready", req_ready, 1);
    repeat (2) @(posedge aclk);
    #1 areset = 0; r_dly = 0;
    @(negedge aclk);
    chk("post_reset_req_ready", req_ready, 1);
    repeat (4) @(posedge aclk);
    #1;
    do_txn(1, 32'hC, 32'h5A5A_0F0F, 4'hF, 0, e, r);
    chk("post_reset_write_err", e, 0);
    do_txn(0, 32'hC, 32'h0, 4'h0, 0, e, r);
    chk("post_reset_read", r, 32'h5A5A_0F0F);
    chk("post_reset_read_lat", rsp_lat, 3);

    for (int i = 0; i < 150; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      pick = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (pick == 7) a = 32'h4;
      else if (pick == 8) a = a | 32'($urandom_range(1, 3));
      else if (pick == 9) a = 32'h100 + a;
      do_txn($urandom_range(0, 1), a, $urandom, 4'($urandom), $urandom_range(0, 2), e, r);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
    end
    repeat (3) @(posedge aclk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
